lru_update_ctrl: RTL

Sequencing controller that sits directly upstream of the cache's LRU memory block. It accepts one access report per transaction (set index, hit/miss, hit way), reads the four per-way 2-bit age counters for that set, computes the next ages, and writes them back. On a miss it also returns the victim way. Counters of a healthy set are always a permutation of 0..3.

---
 rtl/lru_update_ctrl_pkg.sv | 23 ++
 rtl/lru_update_ctrl_if.sv | 43 ++++
 rtl/lru_update_ctrl_next_calc.sv | 68 ++++++
 rtl/lru_update_ctrl.sv | 110 +++++++++++
 4 files changed

// File: rtl/lru_update_ctrl_pkg.sv
// Shared types and constants for the LRU age update controller.
// Ages are 2-bit counters, 0 = most recently used.
package lru_update_ctrl_pkg;

    localparam int LRU_W = 2;

    typedef logic [LRU_W-1:0] age_t;
    typedef age_t [3:0] ages_t;

    localparam age_t AGE_MRU = 2'd0;
    localparam age_t AGE_LRU = 2'd3;

    // Ways 0..3 take ages 0..3 respectively
    localparam ages_t AGE_RST = {2'd3, 2'd2, 2'd1, 2'd0};

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOKUP,
        S_WRITE,
        S_RESP
    } state_t;

endpackage

// File: rtl/lru_update_ctrl_if.sv
// Access-report request and update-done response handshake bundle.
// master = reporting side, slave = controller.
interface lru_update_ctrl_if
    import lru_update_ctrl_pkg::*;
#(
    parameter int indexWidth = 6
);

    logic                  req_valid;
    logic                  req_ready;
    logic [indexWidth-1:0] req_index;
    logic                  req_hit;
    age_t                  req_way;
    logic                  resp_valid;
    logic                  resp_ready;
    age_t                  resp_way;
    logic                  resp_err;

    modport master (
        output req_valid,
        output req_index,
        output req_hit,
        output req_way,
        output resp_ready,
        input  req_ready,
        input  resp_valid,
        input  resp_way,
        input  resp_err
    );

    modport slave (
        input  req_valid,
        input  req_index,
        input  req_hit,
        input  req_way,
        input  resp_ready,
        output req_ready,
        output resp_valid,
        output resp_way,
        output resp_err
    );

endinterface

// File: rtl/lru_update_ctrl_next_calc.sv
// Combinational next-age computation for one 4-way set.
// Flags and repairs sets whose ages are not a permutation of 0..3.
module lru_next_calc
    import lru_update_ctrl_pkg::*;
(
    input  ages_t i_ages,
    input  logic  i_hit,
    input  age_t  i_way,
    output ages_t o_ages,
    output age_t  o_way,
    output logic  o_err
);

    logic [3:0] w_seen;
    age_t       w_hit_age;
    age_t       w_victim;
    logic       w_found;

    always_comb begin
        w_seen = '0;
        for (int i = 0; i < 4; i++) begin
            w_seen[i_ages[i]] = 1'b1;
        end
    end

    assign o_err     = ~&w_seen;
    assign w_hit_age = i_ages[i_way];

    always_comb begin
        w_victim = AGE_LRU;
        w_found  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!w_found && i_ages[i] == AGE_LRU) begin
                w_victim = age_t'(i);
                w_found  = 1'b1;
            end
        end
    end

    always_comb begin
        o_ages = AGE_RST;
        o_way  = i_hit ? i_way : w_victim;
        if (o_err) begin
            // Repaired set: a miss refills the way left oldest by the reset pattern
            o_ages = AGE_RST;
            o_way  = i_hit ? i_way : age_t'(3);
        end else if (i_hit) begin
            for (int i = 0; i < 4; i++) begin
                if (age_t'(i) == i_way) begin
                    o_ages[i] = AGE_MRU;
                end else if (i_ages[i] < w_hit_age) begin
                    o_ages[i] = age_t'(i_ages[i] + age_t'(1));
                end else begin
                    o_ages[i] = i_ages[i];
                end
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (age_t'(i) == w_victim) begin
                    o_ages[i] = AGE_MRU;
                end else begin
                    o_ages[i] = age_t'(i_ages[i] + age_t'(1));
                end
            end
        end
    end

endmodule

// File: rtl/lru_update_ctrl.sv
// Read-modify-write sequencer for the per-set LRU age memory.
// One access report in, one age write-back and one response out.
module lru_update_ctrl
    import lru_update_ctrl_pkg::*;
#(
    parameter int NoOfSets   = 64,
    parameter int indexWidth = 6
)(
    input  logic                  clk,
    input  logic                  reset,
    lru_update_ctrl_if.slave      bus,
    output logic [indexWidth-1:0] lru_index,
    output logic                  LRUwEn,
    output logic [LRU_W-1:0]      lruIn0,
    output logic [LRU_W-1:0]      lruIn1,
    output logic [LRU_W-1:0]      lruIn2,
    output logic [LRU_W-1:0]      lruIn3,
    input  logic [LRU_W-1:0]      lruOut0,
    input  logic [LRU_W-1:0]      lruOut1,
    input  logic [LRU_W-1:0]      lruOut2,
    input  logic [LRU_W-1:0]      lruOut3
);

    // Keeps the memory index inside the set range
    localparam logic [indexWidth-1:0] IDX_MASK =
        indexWidth'(NoOfSets - 1);

    state_t                r_state;
    logic [indexWidth-1:0] r_lru_index;
    logic                  r_hit;
    age_t                  r_way;
    ages_t                 r_age;
    logic                  r_wen;
    logic                  r_resp_valid;
    age_t                  r_resp_way;
    logic                  r_resp_err;

    ages_t                 w_next;
    age_t                  w_way;
    logic                  w_err;

    lru_next_calc u_calc (
        .i_ages (r_age),
        .i_hit  (r_hit),
        .i_way  (r_way),
        .o_ages (w_next),
        .o_way  (w_way),
        .o_err  (w_err)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_lru_index  <= '0;
            r_hit        <= 1'b0;
            r_way        <= '0;
            r_age        <= AGE_RST;
            r_wen        <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_way   <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_lru_index <= bus.req_index & IDX_MASK;
                        r_hit       <= bus.req_hit;
                        r_way       <= bus.req_way;
                        r_state     <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    r_age   <= {lruOut3, lruOut2, lruOut1, lruOut0};
                    r_wen   <= 1'b1;
                    r_state <= S_WRITE;
                end
                S_WRITE: begin
                    r_wen        <= 1'b0;
                    r_lru_index  <= '0;
                    r_resp_way   <= w_way;
                    r_resp_err   <= w_err;
                    r_resp_valid <= 1'b1;
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    if (bus.resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (r_state == S_IDLE) && !reset;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_way   = r_resp_way;
    assign bus.resp_err   = r_resp_err;

    assign lru_index = r_lru_index;
    assign LRUwEn    = r_wen;

    // Write data is only meaningful while the enable is up
    assign lruIn0 = r_wen ? w_next[0] : '0;
    assign lruIn1 = r_wen ? w_next[1] : '0;
    assign lruIn2 = r_wen ? w_next[2] : '0;
    assign lruIn3 = r_wen ? w_next[3] : '0;

endmodule
